// File: rtl/ddr4_chk_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ddr4_chk_pkg
//  Purpose  : Shared widths, the queued read-command record and the
//             expected-data generator for the DDR4 read-data checker.
//  Contents : DDR_AW / DDR_DW / DDR_SW widths, UNEXP_ADDR marker,
//             cmd_t {addr, size}, exp_beat(seed, addr).
//  Revision : 1.0  initial release
// ============================================================================
package ddr4_chk_pkg;

  localparam int DDR_AW = 26;
  localparam int DDR_DW = 512;
  localparam int DDR_SW = 7;

  // Address reported for a beat that arrives with no command outstanding.
  localparam logic [DDR_AW-1:0] UNEXP_ADDR = '1;

  typedef struct packed {
    logic [DDR_AW-1:0] addr;
    logic [DDR_SW-1:0] size;
  } cmd_t;

  // Expected beat: the seeded beat address replicated across the data bus.
  function automatic logic [DDR_DW-1:0] exp_beat(input logic [31:0]       seed,
                                                 input logic [DDR_AW-1:0] addr);
    return {(DDR_DW/32){seed ^ {{(32-DDR_AW){1'b0}}, addr}}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ddr4_chk_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : ddr4_chk_cmd_fifo
//  Purpose  : Synchronous FIFO of outstanding read commands (cmd_t entries).
//             A push into a full FIFO is accepted when a pop happens in the
//             same cycle.
//  Ports    : sync_clk, reset_n (sync, active-low)
//             push/push_data : enqueue request and entry
//             pop            : dequeue head (ignored when empty)
//             head           : current head entry
//             full / empty   : occupancy status
//  Revision : 1.0  initial release
// ============================================================================
module ddr4_chk_cmd_fifo
  import ddr4_chk_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic sync_clk,
  input  logic reset_n,
  input  logic push,
  input  cmd_t push_data,
  input  logic pop,
  output cmd_t head,
  output logic full,
  output logic empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  cmd_t             mem_q [DEPTH];
  cmd_t             mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_en;
  logic             pop_en;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign pop_en  = pop & ~empty;
  // When full, the slot being written is the head slot being vacated.
  assign push_en = push & (~full | pop_en);
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge sync_clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge sync_clk) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: rtl/ddr4_rdata_checker.sv
`default_nettype none
// ============================================================================
//  Module   : ddr4_rdata_checker
//  Purpose  : Passive read-back checker on the DDR4 Avalon-MM user interface.
//             Queues accepted read commands, compares every returned beat
//             against an address-derived pattern through a 2-stage pipeline
//             and keeps beat/error statistics and sticky fault flags.
//  Ports    : sync_clk, reset_n (sync, active-low)
//             avl_ready, avl_read_req, avl_addr, avl_size  : command snoop
//             avl_rdata_valid, avl_rdata                   : beat snoop
//             chk_clear                                    : clear stats/flags
//             chk_busy, chk_done, beat_cnt, err_cnt, err_flag,
//             first_err_addr, ovf_flag, unexp_flag, timeout_flag : status
//  Config   : DDR4_CHK_TIMEOUT_EN enables the idle-timeout watchdog; when
//             undefined timeout_flag is tied low.
//  Revision : 1.0  initial release
// ============================================================================
module ddr4_rdata_checker
  import ddr4_chk_pkg::*;
#(
  parameter int unsigned CMD_DEPTH      = 8,
`ifdef DDR4_CHK_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = 1024,
`endif
  parameter logic [31:0] PATTERN_SEED   = 32'hA5A5_0000
) (
  input  logic              sync_clk,
  input  logic              reset_n,
  input  logic              avl_ready,
  input  logic              avl_read_req,
  input  logic [DDR_AW-1:0] avl_addr,
  input  logic [DDR_SW-1:0] avl_size,
  input  logic              avl_rdata_valid,
  input  logic [DDR_DW-1:0] avl_rdata,
  input  logic              chk_clear,
  output logic              chk_busy,
  output logic              chk_done,
  output logic [31:0]       beat_cnt,
  output logic [15:0]       err_cnt,
  output logic              err_flag,
  output logic [DDR_AW-1:0] first_err_addr,
  output logic              ovf_flag,
  output logic              unexp_flag,
  output logic              timeout_flag
);

  // ---------------------------------------------------------------- queue
  logic cmd_push, cmd_pop, q_full, q_empty;
  cmd_t cmd_in, head;

  assign cmd_push    = avl_read_req & avl_ready;
  assign cmd_in.addr = avl_addr;
  assign cmd_in.size = (avl_size == '0) ? DDR_SW'(1) : avl_size;

  ddr4_chk_cmd_fifo #(
    .DEPTH     (CMD_DEPTH)
  ) u_cmd_fifo (
    .sync_clk  (sync_clk),
    .reset_n   (reset_n),
    .push      (cmd_push),
    .push_data (cmd_in),
    .pop       (cmd_pop),
    .head      (head),
    .full      (q_full),
    .empty     (q_empty)
  );

  // ------------------------------------------------------- beat tracking
  logic [DDR_SW-1:0] beat_idx_q, beat_idx_d;
  logic              beat_hit;
  logic              beat_last;
  logic [DDR_AW-1:0] beat_addr;

  assign beat_hit  = avl_rdata_valid & ~q_empty;
  assign beat_last = (beat_idx_q == head.size - DDR_SW'(1));
  assign cmd_pop   = beat_hit & beat_last;
  assign beat_addr = head.addr + DDR_AW'(beat_idx_q);

  always_comb begin
    beat_idx_d = beat_idx_q;
    if (beat_hit) begin
      beat_idx_d = beat_last ? '0 : beat_idx_q + DDR_SW'(1);
    end
  end

  // ---------------------------------------------------- compare pipeline
  logic              s1_valid_q, s1_valid_d;
  logic              s1_unexp_q, s1_unexp_d;
  logic              s1_last_q,  s1_last_d;
  logic [DDR_AW-1:0] s1_addr_q,  s1_addr_d;
  logic [DDR_DW-1:0] s1_rdata_q, s1_rdata_d;
  logic [DDR_DW-1:0] s1_exp_q,   s1_exp_d;
  logic              s2_valid_q, s2_valid_d;
  logic              s2_err_q,   s2_err_d;
  logic              s2_last_q,  s2_last_d;
  logic [DDR_AW-1:0] s2_addr_q,  s2_addr_d;

  always_comb begin
    s1_valid_d = avl_rdata_valid;
    s1_unexp_d = avl_rdata_valid & q_empty;
    s1_last_d  = cmd_pop;
    s1_addr_d  = q_empty ? UNEXP_ADDR : beat_addr;
    s1_rdata_d = avl_rdata;
    s1_exp_d   = exp_beat(PATTERN_SEED, beat_addr);
    s2_valid_d = s1_valid_q;
    // An unexpected beat is an error whatever its data.
    s2_err_d   = s1_unexp_q | (s1_rdata_q != s1_exp_q);
    s2_last_d  = s1_last_q;
    s2_addr_d  = s1_addr_q;
  end

  // ------------------------------------------------- statistics / flags
  logic [31:0]       beat_cnt_q, beat_cnt_d;
  logic [15:0]       err_cnt_q,  err_cnt_d;
  logic              err_flag_q, err_flag_d;
  logic [DDR_AW-1:0] first_q,    first_d;
  logic              ovf_q,      ovf_d;
  logic              unexp_q,    unexp_d;
  logic              done_q,     done_d;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    err_cnt_d  = err_cnt_q;
    err_flag_d = err_flag_q;
    first_d    = first_q;
    ovf_d      = ovf_q | (cmd_push & q_full & ~cmd_pop);
    unexp_d    = unexp_q | (avl_rdata_valid & q_empty);
    done_d     = s2_valid_q & s2_last_q;
    if (chk_clear) begin
      // Clear takes priority: any beat leaving stage 2 now goes uncounted.
      beat_cnt_d = '0;
      err_cnt_d  = '0;
      err_flag_d = 1'b0;
      first_d    = '0;
      ovf_d      = 1'b0;
      unexp_d    = 1'b0;
    end else if (s2_valid_q) begin
      beat_cnt_d = beat_cnt_q + 32'd1;
      if (s2_err_q) begin
        if (err_cnt_q == '0) begin
          first_d = s2_addr_q;
        end
        if (err_cnt_q != '1) begin
          err_cnt_d = err_cnt_q + 16'd1;
        end
        err_flag_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sync_clk) begin
    if (!reset_n) begin
      beat_idx_q <= '0;
      s1_valid_q <= 1'b0;
      s1_unexp_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_addr_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_err_q   <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_addr_q  <= '0;
      beat_cnt_q <= '0;
      err_cnt_q  <= '0;
      err_flag_q <= 1'b0;
      first_q    <= '0;
      ovf_q      <= 1'b0;
      unexp_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      beat_idx_q <= beat_idx_d;
      s1_valid_q <= s1_valid_d;
      s1_unexp_q <= s1_unexp_d;
      s1_last_q  <= s1_last_d;
      s1_addr_q  <= s1_addr_d;
      s2_valid_q <= s2_valid_d;
      s2_err_q   <= s2_err_d;
      s2_last_q  <= s2_last_d;
      s2_addr_q  <= s2_addr_d;
      beat_cnt_q <= beat_cnt_d;
      err_cnt_q  <= err_cnt_d;
      err_flag_q <= err_flag_d;
      first_q    <= first_d;
      ovf_q      <= ovf_d;
      unexp_q    <= unexp_d;
      done_q     <= done_d;
    end
  end

  // Wide data is qualified by s1_valid_q, so it carries no reset.
  always_ff @(posedge sync_clk) begin
    s1_rdata_q <= s1_rdata_d;
    s1_exp_q   <= s1_exp_d;
  end

  // ------------------------------------------------------- idle timeout
`ifdef DDR4_CHK_TIMEOUT_EN
  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic        timeout_q,  timeout_d;

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    timeout_d  = timeout_q;
    if (q_empty || avl_rdata_valid) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != 16'(TIMEOUT_CYCLES)) begin
      idle_cnt_d = idle_cnt_q + 16'd1;
    end
    // Set only on the crossing, so a clear is not undone by a held count.
    if (chk_clear) begin
      timeout_d = 1'b0;
    end else if (idle_cnt_q != 16'(TIMEOUT_CYCLES) &&
                 idle_cnt_d == 16'(TIMEOUT_CYCLES)) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge sync_clk) begin
    if (!reset_n) begin
      idle_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout_flag = timeout_q;
`else
  assign timeout_flag = 1'b0;
`endif

  // ------------------------------------------------------------ outputs
  assign chk_busy       = ~q_empty | s1_valid_q | s2_valid_q;
  assign chk_done       = done_q;
  assign beat_cnt       = beat_cnt_q;
  assign err_cnt        = err_cnt_q;
  assign err_flag       = err_flag_q;
  assign first_err_addr = first_q;
  assign ovf_flag       = ovf_q;
  assign unexp_flag     = unexp_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr4_rdata_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ddr4_rdata_checker
//  Purpose  : Self-checking bench for ddr4_rdata_checker. A beat-level
//             reference model (queue of expected beat addresses) predicts
//             statistics for directed and randomised traffic.
//  Config   : honours DDR4_CHK_TIMEOUT_EN in test_timeout.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ddr4_rdata_checker;

  localparam logic [31:0] SEED  = 32'hA5A5_0000;
  localparam int          DEPTH = 8;

  logic         sync_clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         avl_ready = 1'b1;
  logic         avl_read_req = 1'b0;
  logic [25:0]  avl_addr = '0;
  logic [6:0]   avl_size = '0;
  logic         avl_rdata_valid = 1'b0;
  logic [511:0] avl_rdata = '0;
  logic         chk_clear = 1'b0;
  logic         chk_busy, chk_done, err_flag, ovf_flag, unexp_flag, timeout_flag;
  logic [31:0]  beat_cnt;
  logic [15:0]  err_cnt;
  logic [25:0]  first_err_addr;

  ddr4_rdata_checker dut (
    .sync_clk        (sync_clk),
    .reset_n         (reset_n),
    .avl_ready       (avl_ready),
    .avl_read_req    (avl_read_req),
    .avl_addr        (avl_addr),
    .avl_size        (avl_size),
    .avl_rdata_valid (avl_rdata_valid),
    .avl_rdata       (avl_rdata),
    .chk_clear       (chk_clear),
    .chk_busy        (chk_busy),
    .chk_done        (chk_done),
    .beat_cnt        (beat_cnt),
    .err_cnt         (err_cnt),
    .err_flag        (err_flag),
    .first_err_addr  (first_err_addr),
    .ovf_flag        (ovf_flag),
    .unexp_flag      (unexp_flag),
    .timeout_flag    (timeout_flag)
  );

  always #5 sync_clk = ~sync_clk;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  always @(negedge sync_clk) if (chk_done === 1'b1) done_seen++;

  // ---------------------------------------------------- reference model
  typedef struct {
    logic [25:0] addr;
    bit          last;
  } beat_t;

  beat_t       m_q[$];
  int          m_ncmd;
  int unsigned m_beat_cnt;
  int          m_err_cnt;
  logic [25:0] m_first;
  bit          m_ovf, m_unexp;
  int          m_done;

  function automatic logic [511:0] pattern(input logic [25:0] a);
    logic [31:0] w;
    w = SEED ^ {6'b0, a};
    return {16{w}};
  endfunction

  task automatic model_clear();
    m_beat_cnt = 0; m_err_cnt = 0; m_first = '0;
    m_ovf = 0; m_unexp = 0; m_done = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_q.delete();
    m_ncmd = 0;
  endtask

  task automatic model_score(input logic [25:0] a, input bit err, input bit last);
    m_beat_cnt++;
    if (err) begin
      if (m_err_cnt == 0) m_first = a;
      if (m_err_cnt < 65535) m_err_cnt++;
    end
    if (last) m_done++;
  endtask

  task automatic model_step(input bit p, input logic [25:0] a, input logic [6:0] sz,
                            input bit v, input logic [511:0] d);
    int    n_before;
    bit    popped;
    int    n;
    beat_t b;
    n_before = m_ncmd;
    popped   = 0;
    if (v) begin
      if (m_q.size() == 0) begin
        m_unexp = 1;
        model_score(26'h3FF_FFFF, 1'b1, 1'b0);
      end else begin
        b = m_q.pop_front();
        model_score(b.addr, d !== pattern(b.addr), b.last);
        if (b.last) begin
          popped = 1;
          m_ncmd--;
        end
      end
    end
    if (p) begin
      if (n_before == DEPTH && !popped) begin
        m_ovf = 1;
      end else begin
        n = (sz == 0) ? 1 : int'(sz);
        for (int i = 0; i < n; i++) begin
          b.addr = a + 26'(i);
          b.last = (i == n - 1);
          m_q.push_back(b);
        end
        m_ncmd++;
      end
    end
  endtask

  // ------------------------------------------------------ stimulus tasks
  task automatic cyc(input bit req, input logic [25:0] a, input logic [6:0] sz,
                     input bit v, input logic [511:0] d, input bit rdy);
    @(negedge sync_clk);
    avl_read_req    = req;
    avl_addr        = a;
    avl_size        = sz;
    avl_rdata_valid = v;
    avl_rdata       = d;
    avl_ready       = rdy;
    model_step(req && rdy, a, sz, v, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, '0, 1'b1);
  endtask

  task automatic send_cmd(input logic [25:0] a, input logic [6:0] sz);
    cyc(1'b1, a, sz, 1'b0, '0, 1'b1);
  endtask

  task automatic send_good_beats();
    while (m_q.size() > 0) cyc(1'b0, '0, '0, 1'b1, pattern(m_q[0].addr), 1'b1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    idle(3);
    while (chk_busy !== 1'b0 && k < 300) begin
      idle(1);
      k++;
    end
    checks++;
    if (chk_busy !== 1'b0) begin
      errors++;
      $display("FAIL drain_busy got=%b required=0", chk_busy);
    end
    idle(2);
  endtask

  task automatic do_clear();
    @(negedge sync_clk);
    avl_read_req = 0; avl_rdata_valid = 0; avl_ready = 1; chk_clear = 1;
    @(negedge sync_clk);
    chk_clear = 0;
    model_clear();
  endtask

  // --------------------------------------------------------------- tests
  task automatic test_reset();
    reset_n = 0;
    model_reset();
    idle(4);
    checks++;
    if ({beat_cnt, err_cnt, err_flag, first_err_addr, ovf_flag, unexp_flag,
         timeout_flag, chk_busy, chk_done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got beat=%0d err=%0d ef=%b first=%h ovf=%b unexp=%b to=%b busy=%b done=%b required all 0",
               beat_cnt, err_cnt, err_flag, first_err_addr, ovf_flag, unexp_flag,
               timeout_flag, chk_busy, chk_done);
    end
    reset_n = 1;
  endtask

  task automatic test_single_burst();
    int base;
    base = done_seen;
    send_cmd(26'd0, 7'd5);
    for (int i = 0; i < 5; i++) cyc(1'b0, '0, '0, 1'b1, pattern(26'(i)), 1'b1);
    idle(2);
    checks++;
    if (chk_done !== 1'b0) begin
      errors++;
      $display("FAIL t1_done_early got=%b required=0", chk_done);
    end
    idle(1);
    checks++;
    if (chk_done !== 1'b1) begin
      errors++;
      $display("FAIL t1_done_latency got=%b required=1", chk_done);
    end
    drain();
    checks++;
    if (beat_cnt !== 32'd5 || err_cnt !== 16'd0 || done_seen - base != 1) begin
      errors++;
      $display("FAIL t1_stats got beat=%0d err=%0d done=%0d required 5 0 1",
               beat_cnt, err_cnt, done_seen - base);
    end
  endtask

  task automatic test_mismatch();
    do_clear();
    send_cmd(26'd3, 7'd3);
    cyc(1'b0, '0, '0, 1'b1, pattern(26'd3), 1'b1);
    cyc(1'b0, '0, '0, 1'b1, 512'd6666, 1'b1);
    cyc(1'b0, '0, '0, 1'b1, pattern(26'd5), 1'b1);
    drain();
    checks++;
    if (err_cnt !== 16'd1 || err_flag !== 1'b1 || first_err_addr !== 26'd4) begin
      errors++;
      $display("FAIL t2_first got err=%0d flag=%b first=%h required 1 1 4",
               err_cnt, err_flag, first_err_addr);
    end
    send_cmd(26'd5, 7'd1);
    cyc(1'b0, '0, '0, 1'b1, ~pattern(26'd5), 1'b1);
    drain();
    checks++;
    if (err_cnt !== 16'd2 || first_err_addr !== 26'd4 || beat_cnt !== 32'd4) begin
      errors++;
      $display("FAIL t2_second got err=%0d first=%h beat=%0d required 2 4 4",
               err_cnt, first_err_addr, beat_cnt);
    end
  endtask

  task automatic test_overflow();
    int base;
    do_clear();
    base = done_seen;
    for (int i = 0; i < 9; i++) send_cmd(26'($urandom), 7'($urandom_range(0, 4)));
    idle(2);
    checks++;
    if (ovf_flag !== 1'b1 || m_ncmd != 8 || chk_busy !== 1'b1) begin
      errors++;
      $display("FAIL t3_ovf got ovf=%b busy=%b required 1 1", ovf_flag, chk_busy);
    end
    send_good_beats();
    drain();
    checks++;
    if (beat_cnt !== 32'(m_beat_cnt) || err_cnt !== 16'd0 || unexp_flag !== 1'b0 ||
        done_seen - base != 8) begin
      errors++;
      $display("FAIL t3_drain got beat=%0d err=%0d unexp=%b done=%0d required %0d 0 0 8",
               beat_cnt, err_cnt, unexp_flag, done_seen - base, m_beat_cnt);
    end
  endtask

  task automatic test_unexpected();
    do_clear();
    cyc(1'b0, '0, '0, 1'b1, {16{$urandom}}, 1'b1);
    drain();
    checks++;
    if (unexp_flag !== 1'b1 || err_cnt !== 16'd1 || first_err_addr !== 26'h3FF_FFFF ||
        beat_cnt !== 32'(m_beat_cnt)) begin
      errors++;
      $display("FAIL t4_unexp got unexp=%b err=%0d first=%h beat=%0d required 1 1 3ffffff %0d",
               unexp_flag, err_cnt, first_err_addr, beat_cnt, m_beat_cnt);
    end
  endtask

  task automatic test_clear_collision();
    do_clear();
    send_cmd(26'd100, 7'd1);
    cyc(1'b0, '0, '0, 1'b1, ~pattern(26'd100), 1'b1);
    idle(1);
    @(negedge sync_clk);
    chk_clear = 1;
    @(negedge sync_clk);
    chk_clear = 0;
    model_clear();
    drain();
    checks++;
    if (beat_cnt !== 32'd0 || err_cnt !== 16'd0 || err_flag !== 1'b0 || first_err_addr !== 26'd0) begin
      errors++;
      $display("FAIL clear_wins got beat=%0d err=%0d flag=%b first=%h required 0 0 0 0",
               beat_cnt, err_cnt, err_flag, first_err_addr);
    end
  endtask

  task automatic test_random();
    int           base;
    bit           req, v, rdy;
    logic [511:0] d;
    int           bi;
    do_clear();
    base = done_seen;
    for (int c = 0; c < 600; c++) begin
      req = (m_ncmd < DEPTH) && ($urandom_range(0, 2) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      if (m_q.size() > 0) begin
        v = ($urandom_range(0, 3) != 0);
        d = pattern(m_q[0].addr);
        if ($urandom_range(0, 7) == 0) begin
          bi = $urandom_range(0, 511);
          d[bi] = ~d[bi];
        end
      end else begin
        v = ($urandom_range(0, 15) == 0);
        d = {16{$urandom}};
      end
      cyc(req, 26'($urandom), 7'($urandom_range(0, 6)), v, d, rdy);
    end
    send_good_beats();
    drain();
    checks++;
    if (beat_cnt !== 32'(m_beat_cnt) || err_cnt !== 16'(m_err_cnt) ||
        err_flag !== (m_err_cnt != 0) || first_err_addr !== m_first) begin
      errors++;
      $display("FAIL rand_stats got beat=%0d err=%0d flag=%b first=%h required %0d %0d %b %h",
               beat_cnt, err_cnt, err_flag, first_err_addr,
               m_beat_cnt, m_err_cnt, m_err_cnt != 0, m_first);
    end
    checks++;
    if (unexp_flag !== m_unexp || ovf_flag !== 1'b0 || done_seen - base != m_done) begin
      errors++;
      $display("FAIL rand_flags got unexp=%b ovf=%b done=%0d required %b 0 %0d",
               unexp_flag, ovf_flag, done_seen - base, m_unexp, m_done);
    end
  endtask

  task automatic test_push_pop_full();
    do_clear();
    for (int i = 0; i < 8; i++) send_cmd(26'(i * 16), 7'd2);
    cyc(1'b0, '0, '0, 1'b1, pattern(26'd0), 1'b1);
    cyc(1'b1, 26'd500, 7'd1, 1'b1, pattern(26'd1), 1'b1);
    idle(2);
    checks++;
    if (ovf_flag !== 1'b0 || m_ncmd != 8) begin
      errors++;
      $display("FAIL t5_push_pop_full got ovf=%b required 0", ovf_flag);
    end
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, '0, 1'b1, pattern(m_q[0].addr), 1'b1);
    @(negedge sync_clk);
    reset_n = 0;
    avl_rdata_valid = 0;
    model_reset();
    idle(3);
    checks++;
    if ({beat_cnt, err_cnt, err_flag, first_err_addr, ovf_flag, unexp_flag,
         timeout_flag, chk_busy, chk_done} !== '0) begin
      errors++;
      $display("FAIL t5_reset got beat=%0d err=%0d busy=%b done=%b required all 0",
               beat_cnt, err_cnt, chk_busy, chk_done);
    end
    reset_n = 1;
    cyc(1'b0, '0, '0, 1'b1, pattern(26'd16), 1'b1);
    drain();
    checks++;
    if (unexp_flag !== 1'b1 || err_cnt !== 16'd1 || first_err_addr !== 26'h3FF_FFFF) begin
      errors++;
      $display("FAIL t5_queue_empty got unexp=%b err=%0d first=%h required 1 1 3ffffff",
               unexp_flag, err_cnt, first_err_addr);
    end
  endtask

  task automatic test_timeout();
    do_clear();
    send_cmd(26'd7, 7'd2);
`ifdef DDR4_CHK_TIMEOUT_EN
    idle(1000);
    checks++;
    if (timeout_flag !== 1'b0) begin
      errors++;
      $display("FAIL t6_early got=%b required=0", timeout_flag);
    end
    idle(40);
    checks++;
    if (timeout_flag !== 1'b1) begin
      errors++;
      $display("FAIL t6_set got=%b required=1", timeout_flag);
    end
    do_clear();
    idle(3);
    checks++;
    if (timeout_flag !== 1'b0) begin
      errors++;
      $display("FAIL t6_clear got=%b required=0", timeout_flag);
    end
`else
    idle(1100);
    checks++;
    if (timeout_flag !== 1'b0) begin
      errors++;
      $display("FAIL t6_disabled got=%b required=0", timeout_flag);
    end
`endif
    send_good_beats();
    drain();
    checks++;
    if (beat_cnt !== 32'd2 || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL t6_drain got beat=%0d err=%0d required 2 0", beat_cnt, err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_mismatch();
    test_overflow();
    test_unexpected();
    test_clear_collision();
    test_random();
    test_push_pop_full();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
